// File: rtl/sdspi_bench_seq.sv
// sdspi_bench_seq: sweeps the SD read system over a range of SCLK speeds.
// For each speed it resets the downstream system for RST_CYCLES cycles,
// starts it, measures the run length in clk cycles and offers one result
// on the res_* channel. A one-cycle done pulse ends the sweep.
// Optional build macro SDSPI_BENCH_TIMEOUT_EN: adds a per-run cycle limit
// of TIMEOUT_CYCLES. When it fires, the run reports res_timeout=1 and res_err=1.
module sdspi_bench_seq #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        abort,
  input  logic [31:0] cfg_n_blocks,
  input  logic        cfg_cmd18,
  input  logic [4:0]  cfg_speed_first,
  input  logic [4:0]  cfg_speed_last,
  output logic        sys_rst,
  output logic        sys_start,
  output logic [31:0] sys_n_blocks,
  output logic        sys_cmd18,
  output logic [4:0]  sys_sclk_speed,
  input  logic        sys_finish,
  input  logic        sys_err,
  input  logic        sys_busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_speed,
  output logic [31:0] res_cycles,
  output logic        res_err,
  output logic        res_timeout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_SYS = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    REPORT  = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  rst_cnt_q;
  logic [31:0] cyc_q;
  logic [31:0] cyc_inc;
  logic [31:0] n_blocks_q;
  logic        cmd18_q;
  logic [4:0]  speed_q;
  logic [4:0]  speed_last_q;
  logic        res_err_q;
  logic        res_to_q;
  logic        timeout_hit;
  logic        run_exit;

  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

`ifdef SDSPI_BENCH_TIMEOUT_EN
  // A finish or error in the same cycle takes precedence over the limit.
  assign timeout_hit = !sys_err && !sys_finish && (cyc_inc >= TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
`endif

  assign run_exit = sys_err || sys_finish || timeout_hit;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = RST_SYS;
      RST_SYS: if (rst_cnt_q == RST_LAST) state_d = START;
      START:   if (sys_busy || sys_finish) state_d = RUN;
      RUN:     if (run_exit) state_d = REPORT;
      REPORT:  if (res_ready) state_d = NEXT;
      NEXT:    state_d = (speed_q >= speed_last_q) ? DONE : RST_SYS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Output decode from the current state.
  always_comb begin
    sys_rst   = 1'b1;
    sys_start = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE:       busy = 1'b0;
      START, RUN: begin
        sys_rst   = 1'b0;
        sys_start = 1'b1;
      end
      REPORT:     res_valid = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Sweep configuration capture, speed stepping, reset timer and run counter.
  // The run counter is zeroed throughout RST_SYS so that it enters START at 0;
  // it then counts the START cycles and every RUN cycle up to the exit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_cnt_q    <= '0;
      cyc_q        <= '0;
      n_blocks_q   <= '0;
      cmd18_q      <= 1'b0;
      speed_q      <= '0;
      speed_last_q <= '0;
      res_err_q    <= 1'b0;
      res_to_q     <= 1'b0;
    end else begin
      if (state_q == RST_SYS) rst_cnt_q <= rst_cnt_q + 8'd1;
      else                    rst_cnt_q <= '0;

      if (state_q == IDLE && go && !abort) begin
        n_blocks_q   <= cfg_n_blocks;
        cmd18_q      <= cfg_cmd18;
        speed_q      <= cfg_speed_first;
        speed_last_q <= cfg_speed_last;
      end

      if (state_q == NEXT && !abort && speed_q < speed_last_q)
        speed_q <= speed_q + 5'd1;

      case (state_q)
        RST_SYS: cyc_q <= '0;
        START:   cyc_q <= cyc_inc;
        RUN:     cyc_q <= timeout_hit ? TIMEOUT_CYCLES : cyc_inc;
        default: ;
      endcase

      if (state_q == RUN && run_exit) begin
        res_err_q <= sys_err || timeout_hit;
        res_to_q  <= timeout_hit;
      end
    end
  end

  assign sys_n_blocks   = n_blocks_q;
  assign sys_cmd18      = cmd18_q;
  assign sys_sclk_speed = speed_q;
  assign res_speed      = speed_q;
  assign res_cycles     = cyc_q;
  assign res_err        = res_err_q;

`ifdef SDSPI_BENCH_TIMEOUT_EN
  assign res_timeout = res_to_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: doc/sdspi_bench_seq.md
SDSPI_BENCH_SEQ -- requirements
Module: sdspi_bench_seq

Interface
REQ-001 Parameter RST_CYCLES, default 4, number of cycles sys_rst is held high before each run (1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 32'h0100_0000, per-run cycle limit (used only with the Configuration macro).
REQ-003 Port clk, input, 1, sole clock, rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port go, input, 1, start sweep; sampled only in IDLE.
REQ-006 Port abort, input, 1, cancel sweep from any state.
REQ-007 Ports cfg_n_blocks (input, 32), cfg_cmd18 (input, 1), cfg_speed_first (input, 5), cfg_speed_last (input, 5), sweep configuration, captured on go.
REQ-008 Ports sys_rst (output, 1, active-high SD system reset) and sys_start (output, 1), plus sys_n_blocks (output, 32), sys_cmd18 (output, 1) and sys_sclk_speed (output, 5), all driving the downstream SD read system.
REQ-009 Ports sys_finish, sys_err and sys_busy, input, 1 each, status from the SD read system.
REQ-010 Ports res_valid (output, 1), res_ready (input, 1), res_speed (output, 5), res_cycles (output, 32), res_err (output, 1) and res_timeout (output, 1), forming the per-run result channel.
REQ-011 Ports busy (output, 1, sequencer not IDLE) and done (output, 1, one-cycle sweep-complete pulse).

Function
REQ-012 States SHALL be IDLE, RST_SYS, START, RUN, REPORT, NEXT and DONE.
REQ-013 IDLE, go=1: capture cfg_* into registers, set speed_reg=cfg_speed_first, go to RST_SYS.
REQ-014 RST_SYS: sys_rst=1 for exactly RST_CYCLES cycles, then START.
REQ-015 START: sys_start=1, cycle counter cleared to 0; go to RUN on the first cycle where sys_busy=1 or sys_finish=1.
REQ-016 RUN: sys_start held 1; cycle counter +1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-017 RUN exit: sys_err=1 -> REPORT with res_err=1; else sys_finish=1 -> REPORT with res_err=0; if both are 1 in the same cycle, err wins.
REQ-018 sys_n_blocks, sys_cmd18 and sys_sclk_speed SHALL equal the captured registers and speed_reg, stable from RST_SYS through REPORT.
REQ-019 res_cycles SHALL equal the number of clk cycles from entry into START up to and including the RUN exit cycle.
REQ-020 REPORT: sys_rst=1, res_valid=1, res_* stable; on res_valid and res_ready both 1, go to NEXT.
REQ-021 NEXT: if speed_reg >= captured speed_last -> DONE, else speed_reg+1 -> RST_SYS; first > last yields exactly one run at first; speed 31 never wraps.
REQ-022 DONE: done=1 for one cycle, then IDLE.
REQ-023 In IDLE, sys_rst=1, sys_start=0, res_valid=0 and busy=0; busy=1 in all other states.
REQ-024 abort=1 in any state: next state IDLE, with no result or done pulse emitted; abort has priority over all other transitions.
REQ-025 go while busy=1 SHALL be ignored.

Reset
REQ-026 rst=0 asynchronously forces IDLE, with sys_rst=1, and all other outputs plus internal counters and registers set to 0.
REQ-027 Reset mid-run SHALL discard the run with no result emitted; after rst returns high, only a new go starts a sweep.

Configuration
REQ-028 Macro SDSPI_BENCH_TIMEOUT_EN defined: in RUN, if counter reaches TIMEOUT_CYCLES before finish or err, go to REPORT with res_timeout=1, res_err=1 and res_cycles=TIMEOUT_CYCLES.
REQ-029 Macro undefined: no timeout logic; res_timeout is tied 0 and RUN waits indefinitely with the counter saturating.

Verification
REQ-030 go with first=2, last=4, and a system model finishing 100 cycles after start -> three results, speeds 2, 3 and 4, each with res_cycles=100+START latency and res_err=0, then one done pulse.
REQ-031 sys_err pulse during the speed-3 run -> that result has res_err=1, the sweep continues to speed 4, and done is asserted.
REQ-032 res_ready held low for 50 cycles -> res_valid and res_* stay stable, and no sys_start occurs until the handshake completes.
REQ-033 abort during RUN, and separately rst=0 during RUN -> IDLE next cycle (async for rst), no res_valid, no done, sys_rst=1.
REQ-034 With SDSPI_BENCH_TIMEOUT_EN and TIMEOUT_CYCLES=1000, a system model that never finishes -> result with res_timeout=1, res_err=1 and res_cycles=1000.
REQ-035 first=7, last=3 -> exactly one run at speed 7, then done; go asserted during that run is ignored.
